// File: rtl/dsp_ui_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_ui_pkg
//  Brief    : Scan-code, ASCII and LCD text constants plus helpers for the
//             hex key entry front end.
//  Revision : 1.0  initial release
// ============================================================================
package dsp_ui_pkg;

    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    localparam logic [7:0] ASC_BLANK = 8'hA0;
    localparam logic [7:0] ASC_US    = 8'h5F;

    localparam logic [1:0] MODE_WELCOME = 2'b00;
    localparam logic [1:0] MODE_INMEM   = 2'b01;
    localparam logic [1:0] MODE_ACC     = 2'b10;
    localparam logic [1:0] MODE_LOAD    = 2'b11;

    localparam int INMEM_COL = 8;
    localparam int ACC_COL   = 13;
    localparam int KEY_COL   = 4;

    localparam logic [79:0] TXT_WELCOME = "WELCOME :)";
    localparam logic [79:0] TXT_INMEM   = 80'("INMEMORY");
    localparam logic [79:0] TXT_ACC     = 80'("ACC");
    localparam logic [79:0] TXT_LOAD    = "LOADING...";
    localparam logic [79:0] TXT_KEY     = 80'("KEY:");

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Character 'col' of a right-aligned string literal of 'len' characters.
    function automatic logic [7:0] txt_char(input logic [79:0] txt, input int len, input int col);
        logic [79:0] t;
        t = '0;
        if (col < len) begin
            t = txt >> (8 * (len - 1 - col));
            return t[7:0];
        end
        return ASC_BLANK;
    endfunction

    function automatic logic [3:0] nib_at(input logic [31:0] v, input int idx);
        logic [31:0] t;
        t = v >> (4 * idx);
        return t[3:0];
    endfunction

    function automatic logic [7:0] banner_char(input logic [1:0] mode, input int col);
        case (mode)
            MODE_WELCOME: return txt_char(TXT_WELCOME, 10, col);
            MODE_INMEM:   return txt_char(TXT_INMEM, 8, col);
            MODE_ACC:     return txt_char(TXT_ACC, 3, col);
            MODE_LOAD:    return txt_char(TXT_LOAD, 10, col);
            default:      return ASC_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : key_scan_decoder
//  Brief    : Combinational PS/2 set-2 scan-code classifier for hex entry.
//  Revision : 1.0  initial release
// ============================================================================
module key_scan_decoder
    import dsp_ui_pkg::*;
(
    input  logic [7:0] i_code,
    output logic       o_is_digit,
    output logic [3:0] o_nib,
    output logic       o_is_enter,
    output logic       o_is_bksp,
    output logic       o_is_esc,
    output logic       o_is_f0,
    output logic       o_is_e0
);

    always_comb begin
        o_is_digit = 1'b1;
        o_nib      = 4'h0;
        case (i_code)
            8'h45: o_nib = 4'h0;
            8'h16: o_nib = 4'h1;
            8'h1E: o_nib = 4'h2;
            8'h26: o_nib = 4'h3;
            8'h25: o_nib = 4'h4;
            8'h2E: o_nib = 4'h5;
            8'h36: o_nib = 4'h6;
            8'h3D: o_nib = 4'h7;
            8'h3E: o_nib = 4'h8;
            8'h46: o_nib = 4'h9;
            8'h1C: o_nib = 4'hA;
            8'h32: o_nib = 4'hB;
            8'h21: o_nib = 4'hC;
            8'h23: o_nib = 4'hD;
            8'h24: o_nib = 4'hE;
            8'h2B: o_nib = 4'hF;
            default: o_is_digit = 1'b0;
        endcase
    end

    assign o_is_enter = (i_code == SC_ENTER);
    assign o_is_bksp  = (i_code == SC_BKSP);
    assign o_is_esc   = (i_code == SC_ESC);
    assign o_is_f0    = (i_code == SC_BREAK);
    assign o_is_e0    = (i_code == SC_EXT);

endmodule
`default_nettype wire

// File: rtl/hex_key_entry.sv
`default_nettype none
// ============================================================================
//  Module   : hex_key_entry
//  Brief    : Keyboard FIFO reader, hex entry datapath and 2-line LCD frame.
//  Revision : 1.0  initial release
// ============================================================================
module hex_key_entry
    import dsp_ui_pkg::*;
#(
    parameter int NDIGITS     = 3,
    parameter int DISP_DIGITS = 4,
    parameter int LCD_COLS    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     key_code,
    input  logic                           kb_buf_empty,
    output logic                           rd_key_code,
    input  logic [1:0]                     mode,
    input  logic [4*DISP_DIGITS-1:0]       dsply,
    output logic [4*NDIGITS-1:0]           value_out,
    output logic                           value_valid,
    output logic [$clog2(NDIGITS+1)-1:0]   entry_len,
    output logic [16*LCD_COLS-1:0]         char_input,
    output logic                           frame_update
);

    localparam int LW = $clog2(NDIGITS + 1);
    localparam int EW = 4 * NDIGITS;

    state_t                 r_state;
    logic [7:0]             r_key;
    logic                   r_rd;
    logic                   r_brk;
    logic [EW-1:0]          r_entry;
    logic [LW-1:0]          r_len;
    logic [EW-1:0]          r_value;
    logic                   r_valid;
    logic [16*LCD_COLS-1:0] r_frame;
    logic                   r_fupd;

    logic                   w_is_digit;
    logic [3:0]             w_nib;
    logic                   w_is_enter;
    logic                   w_is_bksp;
    logic                   w_is_esc;
    logic                   w_is_f0;
    logic                   w_is_e0;
    logic [EW-1:0]          w_entry_shift;
    wire  [16*LCD_COLS-1:0] w_image;

    key_scan_decoder u_dec (
        .i_code     (r_key),
        .o_is_digit (w_is_digit),
        .o_nib      (w_nib),
        .o_is_enter (w_is_enter),
        .o_is_bksp  (w_is_bksp),
        .o_is_esc   (w_is_esc),
        .o_is_f0    (w_is_f0),
        .o_is_e0    (w_is_e0)
    );

    assign w_entry_shift = (r_entry << 4) | EW'(w_nib);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_key   <= 8'h00;
            r_rd    <= 1'b0;
            r_brk   <= 1'b0;
            r_entry <= '0;
            r_len   <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
        end else begin
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!kb_buf_empty) begin
                        r_key   <= key_code;
                        r_rd    <= 1'b1;
                        r_state <= S_POP;
                    end
                end
                S_POP: r_state <= S_DECODE;
                S_DECODE: begin
                    r_state <= S_IDLE;
                    // A break prefix swallows exactly the following code.
                    if (r_brk) begin
                        r_brk <= 1'b0;
                    end else if (w_is_f0) begin
                        r_brk <= 1'b1;
                    end else if (!w_is_e0) begin
                        if (w_is_digit) begin
                            if (r_len < LW'(NDIGITS)) begin
                                r_entry <= w_entry_shift;
                                r_len   <= r_len + 1'b1;
                            end
                        end else if (w_is_bksp) begin
                            if (r_len != '0) begin
                                r_entry <= r_entry >> 4;
                                r_len   <= r_len - 1'b1;
                            end
                        end else if (w_is_esc) begin
                            r_entry <= '0;
                            r_len   <= '0;
                        end else if (w_is_enter && (r_len != '0)) begin
                            r_value <= r_entry;
                            r_valid <= 1'b1;
                            r_entry <= '0;
                            r_len   <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < LCD_COLS; k++) begin : g_col
        logic [7:0] w_l1;
        logic [7:0] w_l2;

        always_comb begin
            w_l1 = banner_char(mode, k);
            if (mode == MODE_INMEM && k >= INMEM_COL && k < INMEM_COL + DISP_DIGITS) begin
                w_l1 = hex2ascii(nib_at(32'(dsply), DISP_DIGITS - 1 - (k - INMEM_COL)));
            end else if (mode == MODE_ACC && k >= ACC_COL && k < ACC_COL + DISP_DIGITS) begin
                w_l1 = hex2ascii(nib_at(32'(dsply), DISP_DIGITS - 1 - (k - ACC_COL)));
            end
        end

        // Typed digits are echoed msd first, remaining slots shown as '_'.
        always_comb begin
            w_l2 = ASC_BLANK;
            if (k < KEY_COL) begin
                w_l2 = txt_char(TXT_KEY, 4, k);
            end else if (k < KEY_COL + NDIGITS) begin
                if ((k - KEY_COL) < int'(r_len)) begin
                    w_l2 = hex2ascii(nib_at(32'(r_entry), int'(r_len) - 1 - (k - KEY_COL)));
                end else begin
                    w_l2 = ASC_US;
                end
            end
        end

        assign w_image[8*k +: 8]              = w_l1;
        assign w_image[8*(LCD_COLS+k) +: 8]   = w_l2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame <= {(2*LCD_COLS){ASC_BLANK}};
            r_fupd  <= 1'b0;
        end else begin
            r_frame <= w_image;
            r_fupd  <= (w_image != r_frame);
        end
    end

    assign rd_key_code  = r_rd;
    assign value_out    = r_value;
    assign value_valid  = r_valid;
    assign entry_len    = r_len;
    assign char_input   = r_frame;
    assign frame_update = r_fupd;

endmodule
`default_nettype wire
